// File: rtl/tetris_rand_pkg.sv
// Shared constants and types for the piece randomizer.
// Holds piece ID encodings, default LFSR seed/taps, mode encoding and
// the queue-occupancy FSM state type.
package tetris_rand_pkg;

  localparam int unsigned NUM_PIECES = 7;
  localparam int unsigned PIECE_ID_W = 3;

  localparam logic [PIECE_ID_W-1:0] PIECE_I = 3'd0;
  localparam logic [PIECE_ID_W-1:0] PIECE_O = 3'd1;
  localparam logic [PIECE_ID_W-1:0] PIECE_T = 3'd2;
  localparam logic [PIECE_ID_W-1:0] PIECE_S = 3'd3;
  localparam logic [PIECE_ID_W-1:0] PIECE_Z = 3'd4;
  localparam logic [PIECE_ID_W-1:0] PIECE_J = 3'd5;
  localparam logic [PIECE_ID_W-1:0] PIECE_L = 3'd6;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

  localparam logic MODE_UNIFORM = 1'b0;
  localparam logic MODE_BAG     = 1'b1;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/lfsr_galois.sv
// Seedable right-shifting Galois LFSR, steps every cycle.
// Ports: clk, reset_n (async active-low), load/load_val (seed load,
// zero seed replaced by SEED), state (current register value).
module lfsr_galois
  import tetris_rand_pkg::*;
#(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_next;

  // Zero is the lock-up state, so a zero seed falls back to SEED.
  always_comb begin
    state_next = (state >> 1) ^ (state[0] ? TAPS : '0);
    if (load) begin
      state_next = (load_val == '0) ? SEED : load_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEED;
    end else begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/piece_randomizer.sv
// Tetris piece source: LFSR candidates filtered by uniform or 7-bag
// selection, buffered in a preview queue with a valid/ready head.
// Ports: clk, reset_n, seed_load/seed_in (reseed + flush), mode
// (0 uniform, 1 bag), piece_ready (consumer pop), piece_valid/piece_id
// (head), preview/preview_valid (entries behind head), bag_remaining.
module piece_randomizer #(
  parameter int unsigned            LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0]  TAPS          = LFSR_WIDTH'(tetris_rand_pkg::DEFAULT_TAPS),
  parameter logic [LFSR_WIDTH-1:0]  SEED          = LFSR_WIDTH'(tetris_rand_pkg::DEFAULT_SEED),
  parameter int unsigned            NUM_PIECES    = tetris_rand_pkg::NUM_PIECES,
  parameter int unsigned            ID_W          = $clog2(NUM_PIECES),
  parameter int unsigned            PREVIEW_DEPTH = 3,
  parameter int unsigned            REJECT_LIMIT  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          seed_load,
  input  logic [LFSR_WIDTH-1:0]         seed_in,
  input  logic                          mode,
  input  logic                          piece_ready,
  output logic                          piece_valid,
  output logic [ID_W-1:0]               piece_id,
  output logic [PREVIEW_DEPTH*ID_W-1:0] preview,
  output logic [PREVIEW_DEPTH-1:0]      preview_valid,
  output logic [ID_W:0]                 bag_remaining
);

  localparam int unsigned QD      = PREVIEW_DEPTH + 1;
  localparam int unsigned CNT_W   = $clog2(QD + 1);
  localparam int unsigned REJ_W   = $clog2(REJECT_LIMIT + 1);
  localparam int unsigned REM_W   = ID_W + 1;
  localparam int unsigned PAD_W   = 2 ** ID_W;

  tetris_rand_pkg::fill_state_e state, state_next;

  logic [LFSR_WIDTH-1:0] lfsr;
  logic [ID_W-1:0]       q      [QD];
  logic [ID_W-1:0]       q_next [QD];
  logic [CNT_W-1:0]      count, count_next, wr_idx;
  logic [NUM_PIECES-1:0] drawn, drawn_next;
  logic [PAD_W-1:0]      drawn_pad;
  logic [REJ_W-1:0]      rej_cnt, rej_next;
  logic [REM_W-1:0]      rem_next;
  logic [PREVIEW_DEPTH-1:0] pv_next;
  logic                  valid_next;
  logic                  bag_mode, pop, cand_ok, fallback, space, accept;
  logic [ID_W-1:0]       cand, low_free, pick;
  logic                  unused_lfsr;

  lfsr_galois #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr)
  );

  // Only the low ID bits form the candidate.
  assign unused_lfsr = ^lfsr[LFSR_WIDTH-1:ID_W];

  // Candidate selection, queue update, bag bookkeeping and next state.
  always_comb begin
    state_next = state;
    count_next = count;
    drawn_next = drawn;
    rej_next   = rej_cnt;
    for (int i = 0; i < int'(QD); i++) q_next[i] = q[i];

    bag_mode  = (mode == tetris_rand_pkg::MODE_BAG);
    cand      = lfsr[ID_W-1:0];
    pop       = piece_valid && piece_ready;
    drawn_pad = PAD_W'(drawn);
    cand_ok   = (32'(cand) < NUM_PIECES) && !(bag_mode && drawn_pad[cand]);
    fallback  = bag_mode && (rej_cnt >= REJ_W'(REJECT_LIMIT));

    // Lowest-index undrawn ID; the bag never stays full, so one exists.
    low_free = '0;
    for (int i = int'(NUM_PIECES) - 1; i >= 0; i--) begin
      if (!drawn[i]) low_free = ID_W'(i);
    end

    pick   = cand_ok ? cand : low_free;
    space  = (state == tetris_rand_pkg::ST_FILL) || pop;
    accept = (cand_ok || fallback) && space;
    wr_idx = count - CNT_W'(pop);

    if (seed_load) begin
      state_next = tetris_rand_pkg::ST_FILL;
      count_next = '0;
      drawn_next = '0;
      rej_next   = '0;
      for (int i = 0; i < int'(QD); i++) q_next[i] = '0;
    end else begin
      // Pop shifts zeros in so invalid slots always read as 0.
      if (pop) begin
        for (int i = 0; i < int'(QD) - 1; i++) q_next[i] = q[i+1];
        q_next[QD-1] = '0;
      end
      if (accept) begin
        for (int i = 0; i < int'(QD); i++) begin
          if (CNT_W'(i) == wr_idx) q_next[i] = pick;
        end
      end
      count_next = wr_idx + CNT_W'(accept);

      if (!bag_mode) begin
        drawn_next = '0;
        rej_next   = '0;
      end else if (accept) begin
        drawn_next = drawn | (NUM_PIECES'(1) << pick);
        if (&drawn_next) drawn_next = '0;
        rej_next = '0;
      end else if (!cand_ok && !fallback) begin
        rej_next = rej_cnt + REJ_W'(1);
      end

      state_next = (count_next == CNT_W'(QD)) ? tetris_rand_pkg::ST_FULL
                                               : tetris_rand_pkg::ST_FILL;
    end

    rem_next = '0;
    for (int i = 0; i < int'(NUM_PIECES); i++) begin
      if (!drawn_next[i]) rem_next = rem_next + REM_W'(1);
    end

    valid_next = (count_next != '0);
    for (int k = 0; k < int'(PREVIEW_DEPTH); k++) begin
      pv_next[k] = (count_next > CNT_W'(k + 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= tetris_rand_pkg::ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count         <= '0;
      drawn         <= '0;
      rej_cnt       <= '0;
      piece_valid   <= 1'b0;
      preview_valid <= '0;
      bag_remaining <= REM_W'(NUM_PIECES);
      for (int i = 0; i < int'(QD); i++) q[i] <= '0;
    end else begin
      count         <= count_next;
      drawn         <= drawn_next;
      rej_cnt       <= rej_next;
      piece_valid   <= valid_next;
      preview_valid <= pv_next;
      bag_remaining <= rem_next;
      for (int i = 0; i < int'(QD); i++) q[i] <= q_next[i];
    end
  end

  // Head and preview slots are the queue registers themselves.
  assign piece_id = q[0];
  for (genvar k = 0; k < int'(PREVIEW_DEPTH); k++) begin : g_preview
    assign preview[k*ID_W +: ID_W] = q[k+1];
  end

endmodule
